// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port data memory between instruction fetch
// (IF) and the load/store unit (LS). LS has fixed priority, with a starvation
// guard that lets IF win after STARVE_MAX consecutive contended LS grants.
// Each access is bounded by an ack timeout. All outputs are registered.
module mem_arbiter #(
  parameter int TIMEOUT    = 16,
  parameter int STARVE_MAX = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  input  logic [3:0]  ls_wstrb,
  output logic        ls_gnt,
  output logic        ls_valid,
  output logic [31:0] ls_rdata,
  output logic        ls_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  // The wait counter only needs to reach TIMEOUT-1; keep at least one bit.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int STV_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state, w_state_next;
  logic [CNT_W-1:0]  r_cnt, w_cnt_next;
  logic [STV_W-1:0]  r_starve, w_starve_next;
  logic              r_owner_ls, w_owner_ls_next;
  logic              r_if_gnt, w_if_gnt_next;
  logic              r_ls_gnt, w_ls_gnt_next;
  logic              r_if_valid, w_if_valid_next;
  logic              r_ls_valid, w_ls_valid_next;
  logic [31:0]       r_if_rdata, w_if_rdata_next;
  logic              r_if_err, w_if_err_next;
  logic [31:0]       r_ls_rdata, w_ls_rdata_next;
  logic              r_ls_err, w_ls_err_next;
  logic              r_mem_en, w_mem_en_next;
  logic              r_mem_we, w_mem_we_next;
  logic [31:0]       r_mem_addr, w_mem_addr_next;
  logic [31:0]       r_mem_wdata, w_mem_wdata_next;
  logic [3:0]        r_mem_wstrb, w_mem_wstrb_next;
  logic              w_done;
  logic [31:0]       w_done_rdata;
  logic              w_done_err;
  logic              w_contend;
  logic              w_ls_wins;

  // LS wins unless IF is also waiting and has already been passed over
  // STARVE_MAX times in a row.
  assign w_contend = if_req && ls_req;
  assign w_ls_wins = ls_req && (!if_req || (r_starve < STV_MAX));

  // Next-state and registered-output computation for IDLE -> BUSY -> RESP.
  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_starve_next    = r_starve;
    w_owner_ls_next  = r_owner_ls;
    w_if_gnt_next    = 1'b0;
    w_ls_gnt_next    = 1'b0;
    w_if_valid_next  = 1'b0;
    w_ls_valid_next  = 1'b0;
    w_if_rdata_next  = r_if_rdata;
    w_if_err_next    = r_if_err;
    w_ls_rdata_next  = r_ls_rdata;
    w_ls_err_next    = r_ls_err;
    w_mem_en_next    = r_mem_en;
    w_mem_we_next    = r_mem_we;
    w_mem_addr_next  = r_mem_addr;
    w_mem_wdata_next = r_mem_wdata;
    w_mem_wstrb_next = r_mem_wstrb;
    w_done           = 1'b0;
    w_done_rdata     = '0;
    w_done_err       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (if_req || ls_req) begin
          w_state_next    = S_BUSY;
          w_cnt_next      = '0;
          w_mem_en_next   = 1'b1;
          w_owner_ls_next = w_ls_wins;
          if (w_ls_wins) begin
            w_ls_gnt_next    = 1'b1;
            w_mem_we_next    = ls_we;
            w_mem_addr_next  = ls_addr;
            w_mem_wdata_next = ls_wdata;
            w_mem_wstrb_next = ls_wstrb;
            // Only contended wins count against IF; the guard keeps it
            // below the saturation point so no explicit clamp is needed.
            if (w_contend) begin
              w_starve_next = r_starve + 1'b1;
            end
          end else begin
            w_if_gnt_next    = 1'b1;
            w_mem_we_next    = 1'b0;
            w_mem_addr_next  = if_addr;
            w_mem_wdata_next = '0;
            w_mem_wstrb_next = '0;
            w_starve_next    = '0;
          end
        end
      end
      S_BUSY: begin
        // Ack beats timeout when both land on the last allowed cycle.
        if (mem_ack) begin
          w_done       = 1'b1;
          w_done_rdata = r_mem_we ? 32'd0 : mem_rdata;
        end else if (r_cnt == CNT_LAST) begin
          w_done     = 1'b1;
          w_done_err = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
        if (w_done) begin
          w_state_next  = S_RESP;
          w_mem_en_next = 1'b0;
          if (r_owner_ls) begin
            w_ls_valid_next = 1'b1;
            w_ls_rdata_next = w_done_rdata;
            w_ls_err_next   = w_done_err;
          end else begin
            w_if_valid_next = 1'b1;
            w_if_rdata_next = w_done_rdata;
            w_if_err_next   = w_done_err;
          end
        end
      end
      S_RESP: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_starve    <= '0;
      r_owner_ls  <= 1'b0;
      r_if_gnt    <= 1'b0;
      r_ls_gnt    <= 1'b0;
      r_if_valid  <= 1'b0;
      r_ls_valid  <= 1'b0;
      r_if_rdata  <= '0;
      r_if_err    <= 1'b0;
      r_ls_rdata  <= '0;
      r_ls_err    <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_starve    <= w_starve_next;
      r_owner_ls  <= w_owner_ls_next;
      r_if_gnt    <= w_if_gnt_next;
      r_ls_gnt    <= w_ls_gnt_next;
      r_if_valid  <= w_if_valid_next;
      r_ls_valid  <= w_ls_valid_next;
      r_if_rdata  <= w_if_rdata_next;
      r_if_err    <= w_if_err_next;
      r_ls_rdata  <= w_ls_rdata_next;
      r_ls_err    <= w_ls_err_next;
      r_mem_en    <= w_mem_en_next;
      r_mem_we    <= w_mem_we_next;
      r_mem_addr  <= w_mem_addr_next;
      r_mem_wdata <= w_mem_wdata_next;
      r_mem_wstrb <= w_mem_wstrb_next;
    end
  end

  assign if_gnt    = r_if_gnt;
  assign if_valid  = r_if_valid;
  assign if_rdata  = r_if_rdata;
  assign if_err    = r_if_err;
  assign ls_gnt    = r_ls_gnt;
  assign ls_valid  = r_ls_valid;
  assign ls_rdata  = r_ls_rdata;
  assign ls_err    = r_ls_err;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wstrb = r_mem_wstrb;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a timeline model.
module tb_mem_arbiter;

  localparam int TO = 4;
  localparam int SM = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_valid, if_err;
  logic [31:0] if_rdata;
  logic        ls_req, ls_we;
  logic [31:0] ls_addr, ls_wdata;
  logic [3:0]  ls_wstrb;
  logic        ls_gnt, ls_valid, ls_err;
  logic [31:0] ls_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int n_vec = 0;
  int n_err = 0;

  // expected outputs for the current cycle, written by the model
  logic        chk_en = 1'b0;
  logic        e_if_gnt, e_ls_gnt, e_if_valid, e_ls_valid, e_mem_en;
  logic        e_mem_we, e_err;
  logic [31:0] e_mem_addr, e_mem_wdata, e_rdata;
  logic [3:0]  e_mem_wstrb;

  mem_arbiter #(.TIMEOUT(TO), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid),
    .if_rdata(if_rdata), .if_err(if_err),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_wstrb(ls_wstrb), .ls_gnt(ls_gnt), .ls_valid(ls_valid),
    .ls_rdata(ls_rdata), .ls_err(ls_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Arbitration rule: LS wins unless IF also waits and has been passed over SM times.
  function automatic bit arb_ls_wins(bit ir, bit lr, int streak);
    if (ir && lr) return streak < SM;
    return lr;
  endfunction

  function automatic int arb_streak(bit ir, bit lr, int streak);
    if (ir && lr) return (streak < SM) ? streak + 1 : 0;
    if (ir) return 0;
    return streak;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    if_req = 0; if_addr = 0; ls_req = 0; ls_we = 0; ls_addr = 0;
    ls_wdata = 0; ls_wstrb = 0; mem_rdata = 0; mem_ack = 0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Per-cycle compare of DUT outputs against the model, mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("if_gnt", 32'(if_gnt), 32'(e_if_gnt));
      chk("ls_gnt", 32'(ls_gnt), 32'(e_ls_gnt));
      chk("if_valid", 32'(if_valid), 32'(e_if_valid));
      chk("ls_valid", 32'(ls_valid), 32'(e_ls_valid));
      chk("mem_en", 32'(mem_en), 32'(e_mem_en));
      if (e_mem_en) begin
        chk("mem_we", 32'(mem_we), 32'(e_mem_we));
        chk("mem_addr", mem_addr, e_mem_addr);
        chk("mem_wdata", mem_wdata, e_mem_wdata);
        chk("mem_wstrb", 32'(mem_wstrb), 32'(e_mem_wstrb));
      end
      if (e_if_valid) begin
        chk("if_rdata", if_rdata, e_rdata);
        chk("if_err", 32'(if_err), 32'(e_err));
      end
      if (e_ls_valid) begin
        chk("ls_rdata", ls_rdata, e_rdata);
        chk("ls_err", 32'(ls_err), 32'(e_err));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // model state for the random phase
  int          cyc, idle_at, g, blen, dly, streak, n_mem;
  bit          act, own_ls, p_we, lw, if_pend, ls_pend, m_err;
  logic [31:0] p_addr, p_wd, m_rdata;
  logic [3:0]  p_ws;
  logic [5:0]  exp_order;

  initial begin
    do_reset();
    // reset state
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_if_gnt", 32'(if_gnt), 32'd0);
    chk("rst_ls_valid", 32'(ls_valid), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);

    // single IF read, ack one cycle after mem_en
    if_req = 1; if_addr = 32'h100;
    step();
    chk("t1_if_gnt", 32'(if_gnt), 32'd1);
    chk("t1_mem_en", 32'(mem_en), 32'd1);
    chk("t1_mem_addr", mem_addr, 32'h100);
    chk("t1_mem_wstrb", 32'(mem_wstrb), 32'd0);
    step();
    chk("t1_gnt_pulse", 32'(if_gnt), 32'd0);
    mem_ack = 1; mem_rdata = 32'hDEADBEEF;
    step();
    chk("t1_if_valid", 32'(if_valid), 32'd1);
    chk("t1_if_rdata", if_rdata, 32'hDEADBEEF);
    chk("t1_if_err", 32'(if_err), 32'd0);
    chk("t1_ls_valid", 32'(ls_valid), 32'd0);
    chk("t1_mem_en_off", 32'(mem_en), 32'd0);
    mem_ack = 0; mem_rdata = 0; if_req = 0;
    step();
    chk("t1_valid_pulse", 32'(if_valid), 32'd0);

    // LS write
    ls_req = 1; ls_we = 1; ls_addr = 32'h2004; ls_wdata = 32'h12345678; ls_wstrb = 4'b0011;
    step();
    chk("t2_ls_gnt", 32'(ls_gnt), 32'd1);
    chk("t2_mem_we", 32'(mem_we), 32'd1);
    chk("t2_mem_wstrb", 32'(mem_wstrb), 32'h3);
    step();
    chk("t2_mem_wdata", mem_wdata, 32'h12345678);
    chk("t2_mem_addr", mem_addr, 32'h2004);
    mem_ack = 1; mem_rdata = 32'hFFFFFFFF;
    step();
    chk("t2_ls_valid", 32'(ls_valid), 32'd1);
    chk("t2_ls_rdata", ls_rdata, 32'd0);
    mem_ack = 0; ls_req = 0; ls_we = 0;
    step();

    // timeout: no ack, mem_en high exactly TO cycles
    ls_req = 1; ls_addr = 32'h40;
    step();
    n_mem = 0;
    while (mem_en === 1'b1 && n_mem < 10) begin
      n_mem++;
      step();
    end
    chk("t3_mem_en_cycles", 32'(n_mem), 32'(TO));
    chk("t3_ls_valid", 32'(ls_valid), 32'd1);
    chk("t3_ls_err", 32'(ls_err), 32'd1);
    chk("t3_ls_rdata", ls_rdata, 32'd0);
    ls_req = 0; if_req = 1; if_addr = 32'h300;
    step();
    step();
    chk("t3_next_gnt", 32'(if_gnt), 32'd1);
    mem_ack = 1; mem_rdata = 32'h11111111;
    step();
    chk("t3_next_valid", 32'(if_valid), 32'd1);
    mem_ack = 0; if_req = 0;
    step();

    // ack on the last allowed BUSY cycle
    ls_req = 1; ls_addr = 32'h80;
    step(); step(); step(); step();
    chk("t4_mem_en", 32'(mem_en), 32'd1);
    mem_ack = 1; mem_rdata = 32'hA5A5A5A5;
    step();
    chk("t4_ls_err", 32'(ls_err), 32'd0);
    chk("t4_ls_rdata", ls_rdata, 32'hA5A5A5A5);
    mem_ack = 0; ls_req = 0;
    step();

    // reset in the second BUSY cycle
    if_req = 1; if_addr = 32'h500;
    step(); step();
    rst = 1;
    step();
    chk("t5_mem_en", 32'(mem_en), 32'd0);
    chk("t5_if_valid", 32'(if_valid), 32'd0);
    chk("t5_if_rdata", if_rdata, 32'd0);
    chk("t5_ls_rdata", ls_rdata, 32'd0);
    chk("t5_mem_addr", mem_addr, 32'd0);
    rst = 0;
    step();
    chk("t5_if_gnt", 32'(if_gnt), 32'd1);
    chk("t5_if_addr", mem_addr, 32'h500);
    mem_ack = 1;
    step();
    chk("t5_if_valid2", 32'(if_valid), 32'd1);
    mem_ack = 0; if_req = 0;
    step();

    // contention order: model pin and DUT against literal LS,LS,IF,LS,LS,IF
    exp_order = 6'b011011;
    streak = 0;
    for (int k = 0; k < 6; k++) begin
      lw = arb_ls_wins(1'b1, 1'b1, streak);
      streak = arb_streak(1'b1, 1'b1, streak);
      chk("model_order", 32'(lw), 32'(exp_order[k]));
    end
    do_reset();
    mem_ack = 1; if_req = 1; ls_req = 1; if_addr = 32'h10; ls_addr = 32'h20;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("t6_ls_gnt", 32'(ls_gnt), 32'(exp_order[k]));
      chk("t6_if_gnt", 32'(if_gnt), 32'(!exp_order[k]));
      step();
      step();
    end
    mem_ack = 0; if_req = 0; ls_req = 0;

    // randomized traffic against the timeline model
    do_reset();
    act = 0; g = 0; blen = 0; dly = 0; idle_at = 0; cyc = 0; streak = 0;
    if_pend = 0; ls_pend = 0; own_ls = 0; m_err = 0; m_rdata = 0;
    p_we = 0; p_addr = 0; p_wd = 0; p_ws = 0;
    for (int i = 0; i < 4000; i++) begin
      e_if_gnt   = act && cyc == g + 1 && !own_ls;
      e_ls_gnt   = act && cyc == g + 1 && own_ls;
      e_mem_en   = act && cyc >= g + 1 && cyc <= g + blen;
      e_if_valid = act && cyc == g + blen + 1 && !own_ls;
      e_ls_valid = act && cyc == g + blen + 1 && own_ls;
      e_mem_we = p_we; e_mem_addr = p_addr; e_mem_wdata = p_wd; e_mem_wstrb = p_ws;
      e_rdata = m_rdata; e_err = m_err;
      chk_en = 1'b1;
      // the owner drops its request at the edge ending its valid cycle
      if (act && cyc == g + blen + 2) begin
        if (own_ls) ls_pend = 0;
        else if_pend = 0;
      end
      if (!if_pend && $urandom_range(0, 99) < 50) begin
        if_pend = 1; if_addr = $urandom;
      end
      if (!ls_pend && $urandom_range(0, 99) < 50) begin
        ls_pend = 1; ls_we = 1'($urandom_range(0, 1)); ls_addr = $urandom;
        ls_wdata = $urandom; ls_wstrb = 4'($urandom_range(0, 15));
      end
      if_req = if_pend; ls_req = ls_pend;
      mem_rdata = $urandom;
      if (e_mem_en) begin
        mem_ack = (cyc == g + 1 + dly);
        if (mem_ack) m_rdata = p_we ? 32'd0 : mem_rdata;
      end else begin
        mem_ack = ($urandom_range(0, 3) == 0);
      end
      if (cyc == idle_at) begin
        if (if_pend || ls_pend) begin
          lw = arb_ls_wins(if_pend, ls_pend, streak);
          streak = arb_streak(if_pend, ls_pend, streak);
          own_ls = lw; g = cyc; act = 1;
          dly = $urandom_range(0, TO + 1);
          blen = (dly < TO) ? dly + 1 : TO;
          m_err = (dly >= TO);
          m_rdata = 0;
          if (lw) begin
            p_we = ls_we; p_addr = ls_addr; p_wd = ls_wdata; p_ws = ls_wstrb;
          end else begin
            p_we = 0; p_addr = if_addr; p_wd = 0; p_ws = 0;
          end
          idle_at = g + blen + 2;
        end else begin
          idle_at = cyc + 1;
        end
      end
      step();
      cyc++;
    end
    chk_en = 1'b0;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port data memory between instruction fetch (IF) and the load/store unit (LS).
- Sits between the two requesters and the memory. Serialises accesses with a 3-state FSM.
- Gives LS fixed priority, with a starvation guard for IF and a per-access ack timeout.
- Returns read data or an error flag to the winning requester as a one-cycle valid pulse.

Parameters:
TIMEOUT, 16, maximum BUSY cycles waiting for mem_ack before an error response (>=1).
STARVE_MAX, 2, consecutive LS-over-IF grants after which IF wins the next contended arbitration (>=1).

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
if_req  in  1  IF request level, held until if_valid
if_addr  in  32  IF word address
if_gnt  out  1  one-cycle pulse: IF request accepted
if_valid  out  1  one-cycle pulse: IF response present
if_rdata  out  32  IF read data, meaningful while if_valid
if_err  out  1  IF timeout flag, meaningful while if_valid
ls_req  in  1  LS request level, held until ls_valid
ls_we  in  1  1 = write, 0 = read
ls_addr  in  32  LS address
ls_wdata  in  32  LS write data
ls_wstrb  in  4  LS byte enables
ls_gnt  out  1  one-cycle pulse: LS request accepted
ls_valid  out  1  one-cycle pulse: LS response present
ls_rdata  out  32  LS read data, 0 for writes
ls_err  out  1  LS timeout flag
mem_en  out  1  memory access strobe, high for the whole BUSY state
mem_we  out  1  memory write enable
mem_addr  out  32  memory address
mem_wdata  out  32  memory write data
mem_wstrb  out  4  memory byte enables, 4'b0000 for IF reads
mem_rdata  in  32  memory read data, sampled with mem_ack
mem_ack  in  1  memory completion, honoured only in BUSY

Behaviour:
- Reset:
  - All outputs go to 0; FSM goes to IDLE; timeout counter, starvation counter and owner go to 0.
  - Reset in BUSY abandons the access: mem_en is 0 after that edge, and no valid pulse is issued.
- FSM states: IDLE, BUSY, RESP. All outputs are registered.
- IDLE, no request: stay in IDLE; mem_en=0; gnt/valid=0.
- IDLE, any request:
  - Pick the winner and record it as owner.
  - Latch the winner's payload into mem_addr/we/wdata/wstrb. An IF winner gets we=0, wstrb=0, wdata=0.
  - Set mem_en=1, pulse the winner's gnt for one cycle, clear the timeout counter, go to BUSY.
- Arbitration:
  - LS only: LS wins. IF only: IF wins.
  - Both requesting and starve_cnt<STARVE_MAX: LS wins and starve_cnt increments.
  - Both requesting and starve_cnt==STARVE_MAX: IF wins.
  - Any IF grant clears starve_cnt to 0.
  - starve_cnt saturates at STARVE_MAX and is unaffected by LS-only grants.
- BUSY:
  - mem_* outputs hold stable.
  - mem_ack=1: capture mem_rdata (0 if mem_we), err=0, go to RESP.
  - No ack and cnt==TIMEOUT-1: rdata=0, err=1, go to RESP.
  - Otherwise cnt increments.
  - mem_en is therefore high for at most TIMEOUT cycles.
- Leaving BUSY: mem_en deasserts on the same edge that enters RESP.
- RESP:
  - For one cycle, the owner's valid=1 with the captured rdata/err; the other requester's valid=0.
  - Then go to IDLE; valid returns to 0.
  - rdata and err hold their value until the next response.
- Latency and throughput:
  - Minimum latency is 2 cycles: request sampled in IDLE at cycle 0, ack in cycle 1, valid in cycle 2.
  - One access per 3 cycles minimum; no back-to-back grants.
- Requester obligations:
  - req and payload stay stable from assertion until the valid cycle.
  - req is deasserted or re-issued at the edge ending the valid cycle. The following IDLE cycle therefore sees the new level.
  - Arbiter behaviour when req drops before valid is undefined for the dropping requester. The access still completes to memory.
- Ignored events:
  - mem_ack in IDLE or RESP is ignored.
  - A request arriving during BUSY/RESP waits for IDLE.
- Simultaneous events: ack on the same cycle as cnt==TIMEOUT-1 counts as success (ack has priority over timeout).

Test Plan:
- Single IF read: if_addr=0x100, mem_ack 1 cycle after mem_en, mem_rdata=0xDEADBEEF -> if_gnt at cycle 1; if_valid at cycle 3 with if_rdata=0xDEADBEEF, if_err=0; ls_valid stays 0.
- LS write: ls_we=1, ls_addr=0x2004, ls_wdata=0x12345678, ls_wstrb=4'b0011 -> mem_we=1, mem_wstrb=0011, mem_wdata=0x12345678 held during BUSY; ls_valid with ls_rdata=0.
- Contention, STARVE_MAX=2, both requests held continuously with immediate ack -> grant order LS, LS, IF, LS, LS, IF; starve_cnt returns to 0 after each IF grant.
- Timeout, TIMEOUT=4, mem_ack never asserted -> mem_en high exactly 4 cycles; ls_valid=1, ls_err=1, ls_rdata=0; next request granted normally.
- Ack on timeout edge: TIMEOUT=4, mem_ack on the 4th BUSY cycle with mem_rdata=0xA5A5A5A5 -> err=0, rdata=0xA5A5A5A5.
- rst asserted in the 2nd BUSY cycle -> next cycle all outputs 0, FSM in IDLE, no valid pulse; a subsequent IF request gets if_gnt in the cycle after sampling.
